// File: rtl/clut_map_rw_sched.sv
// clut_map_rw_sched
// Runs one clutter-map update pass per frame. It walks the map RAM addresses
// 0..cfg_last_addr and issues one read per address. The read data goes to the
// TAS threshold stage. Each threshold that comes back is written to the address
// it was read from. Read addresses wait in a FIFO until their result returns,
// so any in-order datapath latency works.
//
// Ports
//   sys_clk, rst           clock, asynchronous active-high reset
//   frame_start            pulse, starts a pass (ignored while busy)
//   cfg_last_addr          last cell of the pass, sampled when a pass starts
//   map_rd_en/_addr        map RAM read strobe and address
//   radmap_rd_vld          map_rd_en delayed by RAM_RD_LAT, to threshold stage
//   thresh_valid/_dat      result from threshold stage
//   map_wr_en/_addr/_dat   map RAM write-back
//   busy, frame_done       pass in progress / pass finished pulse
//   err_frame_ovr          frame_start seen while busy
//   err_unexp_ret          result returned with nothing outstanding (dropped)
//
// state   | meaning
// S_IDLE  | waiting for frame_start
// S_READ  | issuing reads, throttled by outstanding count
// S_DRAIN | all reads issued, waiting for remaining write-backs
module clut_map_rw_sched #(
   parameter int ADDR_W     = 12,
   parameter int DAT_W      = 16,
   parameter int RAM_RD_LAT = 2,
   parameter int MAX_OUTSTD = 16
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic [ADDR_W-1:0] cfg_last_addr,
   output logic              map_rd_en,
   output logic [ADDR_W-1:0] map_rd_addr,
   output logic              radmap_rd_vld,
   input  logic              thresh_valid,
   input  logic [DAT_W-1:0]  thresh_dat,
   output logic              map_wr_en,
   output logic [ADDR_W-1:0] map_wr_addr,
   output logic [DAT_W-1:0]  map_wr_dat,
   output logic              busy,
   output logic              frame_done,
   output logic              err_frame_ovr,
   output logic              err_unexp_ret
);

   localparam int PW = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTD);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t                  state;
   logic [ADDR_W-1:0]       addr;
   logic [ADDR_W-1:0]       last_addr;
   logic [CW-1:0]           outstd;
   logic [PW-1:0]           push_ptr;
   logic [PW-1:0]           pop_ptr;
   logic [ADDR_W-1:0]       fifo_mem [MAX_OUTSTD];
   logic [RAM_RD_LAT-1:0]   vld_sr;

   logic pop;
   logic can_issue;
   logic accept;

   // The FIFO holds exactly the outstanding addresses, so "non-empty" is outstd != 0.
   // A result returning this cycle frees a slot for a read issued on the same edge.
   always_comb begin
      pop       = thresh_valid && (outstd != '0);
      can_issue = (state == S_READ) && ((outstd < MAX_C) || pop);
      // A frame_start in the frame_done cycle still counts as arriving while busy.
      accept    = frame_start && (state == S_IDLE) && !frame_done;
   end

   assign radmap_rd_vld = vld_sr[RAM_RD_LAT-1];

   always_ff @(posedge sys_clk) begin
      if (can_issue) fifo_mem[push_ptr] <= addr;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         addr          <= '0;
         last_addr     <= '0;
         outstd        <= '0;
         push_ptr      <= '0;
         pop_ptr       <= '0;
         vld_sr        <= '0;
         map_rd_en     <= 1'b0;
         map_rd_addr   <= '0;
         map_wr_en     <= 1'b0;
         map_wr_addr   <= '0;
         map_wr_dat    <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         err_frame_ovr <= 1'b0;
         err_unexp_ret <= 1'b0;
      end else begin
         map_rd_en     <= can_issue;
         map_wr_en     <= pop;
         frame_done    <= 1'b0;
         err_frame_ovr <= frame_start && !accept;
         err_unexp_ret <= thresh_valid && !pop;

         vld_sr[0] <= map_rd_en;
         for (int i = 1; i < RAM_RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];

         if (can_issue) begin
            map_rd_addr <= addr;
            addr        <= addr + ADDR_W'(1);
            push_ptr    <= push_ptr + PW'(1);
         end
         if (pop) begin
            map_wr_addr <= fifo_mem[pop_ptr];
            map_wr_dat  <= thresh_dat;
            pop_ptr     <= pop_ptr + PW'(1);
         end

         if (can_issue && !pop)      outstd <= outstd + CW'(1);
         else if (!can_issue && pop) outstd <= outstd - CW'(1);

         case (state)
            S_IDLE: begin
               if (accept) begin
                  last_addr <= cfg_last_addr;
                  addr      <= '0;
                  busy      <= 1'b1;
                  state     <= S_READ;
               end
            end
            S_READ: begin
               if (can_issue && (addr == last_addr)) state <= S_DRAIN;
            end
            S_DRAIN: begin
               // The last write strobe is already on the bus when outstd reaches 0.
               if (outstd == '0) begin
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clut_map_rw_sched.sv
// Directed bench for clut_map_rw_sched. Instance 0 uses the default outstanding
// depth (16). Instance 1 uses depth 4. Both share frame control. Each instance
// drives its own echo datapath model: RAM latency plus a selectable threshold
// latency, and the returned data is addr+0x100.
module tb_clut_map_rw_sched;

   logic sys_clk = 1'b0;
   logic rst = 1'b0;
   logic frame_start = 1'b0;
   logic [11:0] cfg_last_addr = '0;
   logic inj = 1'b0;
   logic clr = 1'b0;
   int   lat_sel = 7;

   logic [1:0] busy, rd_en, wr_en, rd_vld, done, ovr, unexp, tv;
   logic [1:0][11:0] rd_addr, wr_addr;
   logic [1:0][15:0] wr_dat, tdat;

   always #5 sys_clk = ~sys_clk;

   clut_map_rw_sched dut (
      .sys_clk(sys_clk), .rst(rst), .frame_start(frame_start), .cfg_last_addr(cfg_last_addr),
      .map_rd_en(rd_en[0]), .map_rd_addr(rd_addr[0]), .radmap_rd_vld(rd_vld[0]),
      .thresh_valid(tv[0]), .thresh_dat(tdat[0]),
      .map_wr_en(wr_en[0]), .map_wr_addr(wr_addr[0]), .map_wr_dat(wr_dat[0]),
      .busy(busy[0]), .frame_done(done[0]), .err_frame_ovr(ovr[0]), .err_unexp_ret(unexp[0]));

   clut_map_rw_sched #(.MAX_OUTSTD(4)) dut_b (
      .sys_clk(sys_clk), .rst(rst), .frame_start(frame_start), .cfg_last_addr(cfg_last_addr),
      .map_rd_en(rd_en[1]), .map_rd_addr(rd_addr[1]), .radmap_rd_vld(rd_vld[1]),
      .thresh_valid(tv[1]), .thresh_dat(tdat[1]),
      .map_wr_en(wr_en[1]), .map_wr_addr(wr_addr[1]), .map_wr_dat(wr_dat[1]),
      .busy(busy[1]), .frame_done(done[1]), .err_frame_ovr(ovr[1]), .err_unexp_ret(unexp[1]));

   // Echo datapath: a read visible in cycle c returns in cycle c+2+lat_sel.
   logic        pipe_v [2][40] = '{default: '0};
   logic [11:0] pipe_a [2][40] = '{default: '0};
   int tap;
   assign tap = lat_sel + 1;

   always @(posedge sys_clk) begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 39; i > 0; i--) begin
            pipe_v[k][i] <= pipe_v[k][i-1];
            pipe_a[k][i] <= pipe_a[k][i-1];
         end
         pipe_v[k][0] <= rd_en[k];
         pipe_a[k][0] <= rd_addr[k];
      end
   end

   assign tv[0]   = pipe_v[0][tap] | inj;
   assign tv[1]   = pipe_v[1][tap] | inj;
   assign tdat[0] = {4'h0, pipe_a[0][tap]} + 16'h0100;
   assign tdat[1] = {4'h0, pipe_a[1][tap]} + 16'h0100;

   // Monitor / scoreboard
   int cyc = 0;
   int rd_n[2], wr_n[2], tv_n[2], max_out[2], done_n[2], ovr_n[2], unexp_n[2], vld_n[2], vld_first[2];
   int rd_c[2][64];
   int wr_a[2][64];
   int wr_d[2][64];
   int mon_o;

   always @(negedge sys_clk) begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (clr) begin
            rd_n[k] = 0; wr_n[k] = 0; tv_n[k] = 0; max_out[k] = 0; done_n[k] = 0;
            ovr_n[k] = 0; unexp_n[k] = 0; vld_n[k] = 0; vld_first[k] = 0;
         end else begin
            if (rd_en[k]) begin
               if (rd_n[k] < 64) rd_c[k][rd_n[k]] = cyc;
               rd_n[k] = rd_n[k] + 1;
            end
            if (wr_en[k]) begin
               if (wr_n[k] < 64) begin
                  wr_a[k][wr_n[k]] = int'(wr_addr[k]);
                  wr_d[k][wr_n[k]] = int'(wr_dat[k]);
               end
               wr_n[k] = wr_n[k] + 1;
            end
            if (rd_vld[k]) begin
               if (vld_n[k] == 0) vld_first[k] = cyc;
               vld_n[k] = vld_n[k] + 1;
            end
            mon_o = rd_n[k] - tv_n[k];
            if (mon_o > max_out[k]) max_out[k] = mon_o;
            if (tv[k] && mon_o > 0) tv_n[k] = tv_n[k] + 1;
            if (done[k])  done_n[k]  = done_n[k] + 1;
            if (ovr[k])   ovr_n[k]   = ovr_n[k] + 1;
            if (unexp[k]) unexp_n[k] = unexp_n[k] + 1;
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_logs;
      clr = 1'b1;
      @(negedge sys_clk);
      #1;
      clr = 1'b0;
   endtask

   function automatic int order_bad(input int k);
      int b = 0;
      for (int i = 0; i < wr_n[k] && i < 64; i++) if (wr_a[k][i] != i) b++;
      return b;
   endfunction

   function automatic int dat_bad(input int k);
      int b = 0;
      for (int i = 0; i < wr_n[k] && i < 64; i++) if (wr_d[k][i] != wr_a[k][i] + 32'h100) b++;
      return b;
   endfunction

   // Run one pass. mid_rd>0: re-pulse frame_start (with a different cfg) once
   // mid_rd reads are seen. done_hit: pulse frame_start in the frame_done cycle.
   task automatic run_pass(input int last, input int lat, input int mid_rd, input bit done_hit);
      bit hit = 1'b0;
      clear_logs();
      lat_sel = lat;
      cfg_last_addr = 12'(last);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (mid_rd > 0 && !hit && rd_n[0] >= mid_rd) begin
            cfg_last_addr = 12'd3;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            cfg_last_addr = 12'(last);
            hit = 1'b1;
         end
         if (done_hit && !hit && done[0]) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            hit = 1'b1;
         end
         if (i > 2 && busy == 2'b00) break;
      end
      repeat (3) tick();
      chk("pass_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      #3 rst = 1'b1;
      repeat (3) tick();
      chk("rst_outputs", {busy[0], rd_en[0], wr_en[0], rd_vld[0], done[0], ovr[0], unexp[0],
                          rd_addr[0], wr_addr[0], wr_dat[0]}, 64'd0);
      rst = 1'b0;
      repeat (2) tick();

      // 8 cells, latency 7: back-to-back reads, in-order writes
      run_pass(7, 7, 0, 1'b0);
      chk("t1_rd_n", rd_n[0], 8);
      chk("t1_rd_span", rd_c[0][7] - rd_c[0][0], 7);
      chk("t1_wr_n", wr_n[0], 8);
      chk("t1_wr_order", order_bad(0), 0);
      chk("t1_done_n", done_n[0], 1);
      chk("t1_vld_lat", vld_first[0] - rd_c[0][0], 2);
      chk("t1_vld_n", vld_n[0], 8);

      // 16 cells, latency 10: depth-4 instance stalls in bursts of 4
      run_pass(15, 10, 0, 1'b0);
      chk("t2_a_rd_span", rd_c[0][15] - rd_c[0][0], 15);
      chk("t2_b_max_out", max_out[1], 4);
      chk("t2_b_rd_span", rd_c[1][15] - rd_c[1][0], 42);
      chk("t2_b_wr_n", wr_n[1], 16);
      chk("t2_b_wr_order", order_bad(1), 0);
      chk("t2_b_done_n", done_n[1], 1);

      // bypass latency 1: data follows address
      run_pass(7, 1, 0, 1'b0);
      chk("t3_wr_n", wr_n[0], 8);
      chk("t3_wr_dat", dat_bad(0), 0);
      chk("t3_b_wr_dat", dat_bad(1), 0);

      // second frame_start mid-pass is ignored
      run_pass(7, 7, 4, 1'b0);
      chk("t4_ovr_n", ovr_n[0], 1);
      chk("t4_rd_n", rd_n[0], 8);
      chk("t4_wr_n", wr_n[0], 8);
      chk("t4_wr_order", order_bad(0), 0);
      chk("t4_done_n", done_n[0], 1);

      // result injected while idle
      clear_logs();
      inj = 1'b1;
      tick();
      inj = 1'b0;
      repeat (3) tick();
      chk("t5_unexp_n", unexp_n[0], 1);
      chk("t5_unexp_wr", wr_n[0], 0);

      // 2-cell pass, then frame_start in the frame_done cycle
      run_pass(1, 3, 0, 1'b1);
      chk("t5_rd_n", rd_n[0], 2);
      chk("t5_wr_order", order_bad(0) + (wr_n[0] == 2 ? 0 : 100), 0);
      chk("t5_done_n", done_n[0], 1);
      chk("t5_ovr_on_done", ovr_n[0], 1);

      // reset mid-pass with 5 reads outstanding
      clear_logs();
      lat_sel = 10;
      cfg_last_addr = 12'd15;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rd_n[0] >= 5) break;
         tick();
      end
      chk("t6_rd_before_rst", rd_n[0], 5);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_rst", {busy[0], rd_en[0], wr_en[0], rd_vld[0], done[0], ovr[0], unexp[0],
                           rd_addr[0], wr_addr[0], wr_dat[0]}, 64'd0);
      repeat (3) tick();
      rst = 1'b0;
      clear_logs();
      repeat (25) tick();
      chk("t6_unexp_n", unexp_n[0], 5);
      chk("t6_no_wr", wr_n[0], 0);

      run_pass(0, 7, 0, 1'b0);
      chk("t6_rd_n", rd_n[0], 1);
      chk("t6_wr_n", wr_n[0], 1);
      chk("t6_wr_addr", wr_a[0][0], 0);
      chk("t6_done_n", done_n[0], 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
